// File: rtl/rotwin_pkg.sv
// Shared definitions for the rotated-window collector: FSM encoding,
// the largest legal rotation index and the width helper.
package rotwin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } rotwin_state_e;

  localparam int ANG_MAX = 35;

  // Ceiling log2, floored at 1 so a degenerate window still gets a real bus.
  function automatic int rotwin_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rotated_window_collector_if.sv
// Request, serializer, sample and window bundle of the rotated-window collector.
// slave = collector side, master = surrounding environment.
interface rotwin_if #(
  parameter int winW   = 4,
  parameter int winH   = winW,
  parameter int dataW  = 8,
  parameter int angleW = 6
);
  localparam int N    = winW * winH;
  localparam int SUMW = dataW + rotwin_pkg::rotwin_clog2(N);

  logic                  req_valid;
  logic                  req_ready;
  logic [angleW-1:0]     req_rotate;
  logic                  ser_load;
  logic [angleW-1:0]     ser_rotate;
  logic                  samp_valid;
  logic [dataW-1:0]      samp_data;
  logic                  win_valid;
  logic                  win_ready;
  logic [N*dataW-1:0]    window_out;
  logic [angleW-1:0]     win_rotate;
  logic                  err_overrun;
  logic                  err_angle;
  logic [SUMW-1:0]       sum_out;

  modport slave (
    input  req_valid, req_rotate, samp_valid, samp_data, win_ready,
    output req_ready, ser_load, ser_rotate, win_valid, window_out,
           win_rotate, err_overrun, err_angle, sum_out
  );

  modport master (
    output req_valid, req_rotate, samp_valid, samp_data, win_ready,
    input  req_ready, ser_load, ser_rotate, win_valid, window_out,
           win_rotate, err_overrun, err_angle, sum_out
  );

endinterface

// File: rtl/rotwin_fsm.sv
// Control for the rotated-window collector: request/window handshakes,
// serializer load pulse, sample slot counter and sticky error flags.
module rotwin_fsm
  import rotwin_pkg::*;
#(
  parameter int N      = 16,
  parameter int angleW = 6,
  parameter int CNTW   = rotwin_clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              req_valid,
  input  logic [angleW-1:0] req_rotate,
  input  logic              samp_valid,
  input  logic              win_ready,
  output logic              req_ready,
  output logic              ser_load,
  output logic [angleW-1:0] ser_rotate,
  output logic              win_valid,
  output logic [angleW-1:0] win_rotate,
  output logic              err_overrun,
  output logic              err_angle,
  output logic              wr_en,
  output logic [CNTW-1:0]   wr_idx,
  output logic              start
);

  localparam logic [angleW-1:0] ANG_LIM  = angleW'(ANG_MAX);
  localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(N - 1);

  rotwin_state_e     state_q, state_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [angleW-1:0] rot_q, rot_d;
  logic              ser_load_q, ser_load_d;
  logic              req_ready_q, req_ready_d;
  logic              win_valid_q, win_valid_d;
  logic              err_overrun_q, err_overrun_d;
  logic              err_angle_q, err_angle_d;

  assign start = en && (state_q == ST_IDLE) && req_valid && (req_rotate <= ANG_LIM);
  assign wr_en = en && (state_q == ST_COLLECT) && samp_valid;
  assign wr_idx = count_q;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rot_d         = rot_q;
    ser_load_d    = ser_load_q;
    req_ready_d   = req_ready_q;
    win_valid_d   = win_valid_q;
    err_overrun_d = err_overrun_q;
    err_angle_d   = err_angle_q;
    if (en) begin
      ser_load_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_rotate > ANG_LIM) begin
              err_angle_d = 1'b1;
            end else begin
              state_d    = ST_COLLECT;
              rot_d      = req_rotate;
              ser_load_d = 1'b1;
              count_d    = '0;
            end
          end
        end
        ST_COLLECT: begin
          if (samp_valid) begin
            // Counter parks on the last slot instead of wrapping.
            if (count_q == CNT_LAST) state_d = ST_HOLD;
            else                     count_d = count_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (win_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (samp_valid && (state_q != ST_COLLECT)) err_overrun_d = 1'b1;
      req_ready_d = (state_d == ST_IDLE);
      win_valid_d = (state_d == ST_HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      rot_q         <= '0;
      ser_load_q    <= 1'b0;
      req_ready_q   <= 1'b1;
      win_valid_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_angle_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rot_q         <= rot_d;
      ser_load_q    <= ser_load_d;
      req_ready_q   <= req_ready_d;
      win_valid_q   <= win_valid_d;
      err_overrun_q <= err_overrun_d;
      err_angle_q   <= err_angle_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign ser_load    = ser_load_q;
  assign ser_rotate  = rot_q;
  assign win_rotate  = rot_q;
  assign win_valid   = win_valid_q;
  assign err_overrun = err_overrun_q;
  assign err_angle   = err_angle_q;

endmodule

// File: rtl/rotated_window_collector.sv
// Collects a serial stream of interpolated samples into a winW x winH window.
// Define ROTWIN_SUM_EN to build the window sample-sum accumulator.
module rotated_window_collector
  import rotwin_pkg::*;
#(
  parameter int winW   = 4,
  parameter int winH   = winW,
  parameter int dataW  = 8,
  parameter int angleW = 6
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  rotwin_if.slave  bus
);

  localparam int N    = winW * winH;
  localparam int CNTW = rotwin_clog2(N);

  logic            wr_en;
  logic [CNTW-1:0] wr_idx;
  logic            start;

  rotwin_fsm #(
    .N      (N),
    .angleW (angleW),
    .CNTW   (CNTW)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req_valid   (bus.req_valid),
    .req_rotate  (bus.req_rotate),
    .samp_valid  (bus.samp_valid),
    .win_ready   (bus.win_ready),
    .req_ready   (bus.req_ready),
    .ser_load    (bus.ser_load),
    .ser_rotate  (bus.ser_rotate),
    .win_valid   (bus.win_valid),
    .win_rotate  (bus.win_rotate),
    .err_overrun (bus.err_overrun),
    .err_angle   (bus.err_angle),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .start       (start)
  );

  // Window slots sit in flops, not RAM: all of them are visible at once and
  // reset must clear them.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    logic [dataW-1:0] slot_q, slot_d;

    always_comb begin
      slot_d = slot_q;
      if (wr_en && (wr_idx == CNTW'(gi))) slot_d = bus.samp_data;
    end

    always_ff @(posedge clk) begin
      if (!rst) slot_q <= '0;
      else      slot_q <= slot_d;
    end

    assign bus.window_out[gi*dataW +: dataW] = slot_q;
  end

`ifdef ROTWIN_SUM_EN
  localparam int SUMW = dataW + CNTW;

  logic [SUMW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start)      sum_d = '0;
    else if (wr_en) sum_d = sum_q + SUMW'(bus.samp_data);
  end

  always_ff @(posedge clk) begin
    if (!rst) sum_q <= '0;
    else      sum_q <= sum_d;
  end

  assign bus.sum_out = sum_q;
`else
  logic unused_start;
  assign unused_start = start;
  assign bus.sum_out  = '0;
`endif

endmodule

// File: tb/tb_rotated_window_collector.sv
// Directed bench for rotated_window_collector (winW=4, dataW=8, N=16);
// expected sums follow ROTWIN_SUM_EN.
module tb_rotated_window_collector;

`ifdef ROTWIN_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic en;
  int   n_checks;
  int   n_pass;

  rotwin_if #(.winW(4), .winH(4), .dataW(8), .angleW(6)) bus ();

  rotated_window_collector #(.winW(4), .winH(4), .dataW(8), .angleW(6)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] exp_win(input logic [7:0] base);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) w[k*8 +: 8] = base + 8'(k);
    return w;
  endfunction

  // Presents one request for exactly one edge.
  task automatic request(input logic [5:0] angle);
    bus.req_valid  = 1'b1;
    bus.req_rotate = angle;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  // 16 back-to-back samples base..base+15; win_valid must stay low until the last edge.
  task automatic feed(input logic [7:0] base);
    for (int k = 0; k < 16; k++) begin
      bus.samp_valid = 1'b1;
      bus.samp_data  = base + 8'(k);
      if (k == 15) check("pre_last_win_valid", 128'(bus.win_valid), 128'(0));
      tick();
    end
    bus.samp_valid = 1'b0;
    check("post_last_win_valid", 128'(bus.win_valid), 128'(1));
  endtask

  task automatic release_win();
    bus.win_ready = 1'b1;
    tick();
    bus.win_ready = 1'b0;
    check("release_win_valid", 128'(bus.win_valid), 128'(0));
    check("release_req_ready", 128'(bus.req_ready), 128'(1));
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst            = 1'b0;
    en             = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_rotate = '0;
    bus.samp_valid = 1'b0;
    bus.samp_data  = '0;
    bus.win_ready  = 1'b0;

    // Reset
    tick();
    tick();
    rst = 1'b1;
    check("rst_req_ready",  128'(bus.req_ready),   128'(1));
    check("rst_win_valid",  128'(bus.win_valid),   128'(0));
    check("rst_ser_load",   128'(bus.ser_load),    128'(0));
    check("rst_ser_rotate", 128'(bus.ser_rotate),  128'(0));
    check("rst_window",     bus.window_out,        128'(0));
    check("rst_sum",        128'(bus.sum_out),     128'(0));
    check("rst_errs",       128'({bus.err_overrun, bus.err_angle}), 128'(0));

    // Basic collect at angle 1
    request(6'd1);
    check("s2_ser_load_hi", 128'(bus.ser_load),   128'(1));
    check("s2_ser_rotate",  128'(bus.ser_rotate), 128'(1));
    check("s2_req_ready",   128'(bus.req_ready),  128'(0));
    tick();
    check("s2_ser_load_lo", 128'(bus.ser_load),   128'(0));
    feed(8'h10);
    check("s2_window",     bus.window_out,        exp_win(8'h10));
    check("s2_win_rotate", 128'(bus.win_rotate),  128'(1));
    check("s2_sum",        128'(bus.sum_out),     SUM_EN ? 128'(376) : 128'(0));
    check("s2_overrun",    128'(bus.err_overrun), 128'(0));
    $display("window angle=%0d collected", bus.win_rotate);

    // Backpressure with overrun samples in HOLD
    for (int c = 0; c < 10; c++) begin
      bus.samp_valid = (c == 2 || c == 5 || c == 8);
      bus.samp_data  = 8'hEE;
      tick();
    end
    bus.samp_valid = 1'b0;
    check("s3_window",    bus.window_out,        exp_win(8'h10));
    check("s3_win_valid", 128'(bus.win_valid),   128'(1));
    check("s3_overrun",   128'(bus.err_overrun), 128'(1));
    release_win();
    $display("window released after backpressure");

    // Gaps and clock enable
    request(6'd1);
    en = 1'b0;
    tick();
    check("s4_ser_load_hold", 128'(bus.ser_load), 128'(1));
    en = 1'b1;
    tick();
    check("s4_ser_load_lo", 128'(bus.ser_load), 128'(0));
    for (int k = 0; k < 16; k++) begin
      if (k == 8) begin
        en             = 1'b0;
        bus.samp_valid = 1'b1;
        bus.samp_data  = 8'h77;
        repeat (3) tick();
        en = 1'b1;
      end
      bus.samp_valid = 1'b1;
      bus.samp_data  = 8'h10 + 8'(k);
      if (k == 15) check("s4_pre_last_win_valid", 128'(bus.win_valid), 128'(0));
      tick();
      bus.samp_valid = 1'b0;
      if (k < 15) tick();
    end
    check("s4_win_valid", 128'(bus.win_valid),  128'(1));
    check("s4_window",    bus.window_out,       exp_win(8'h10));
    check("s4_sum",       128'(bus.sum_out),    SUM_EN ? 128'(376) : 128'(0));
    $display("window angle=%0d collected with gaps", bus.win_rotate);
    release_win();

    // Illegal angle, then a legal one
    request(6'd36);
    check("s5_ser_load",  128'(bus.ser_load),   128'(0));
    check("s5_err_angle", 128'(bus.err_angle),  128'(1));
    check("s5_req_ready", 128'(bus.req_ready),  128'(1));
    check("s5_ser_rotate_kept", 128'(bus.ser_rotate), 128'(1));
    request(6'd0);
    check("s5b_ser_load",   128'(bus.ser_load),   128'(1));
    check("s5b_ser_rotate", 128'(bus.ser_rotate), 128'(0));
    tick();
    feed(8'h30);
    check("s5b_window",     bus.window_out,       exp_win(8'h30));
    check("s5b_win_rotate", 128'(bus.win_rotate), 128'(0));
    check("s5b_sum",        128'(bus.sum_out),    SUM_EN ? 128'(888) : 128'(0));
    $display("window angle=%0d collected after illegal request", bus.win_rotate);
    release_win();

    // Mid-collect reset
    request(6'd5);
    tick();
    for (int k = 0; k < 7; k++) begin
      bus.samp_valid = 1'b1;
      bus.samp_data  = 8'h50 + 8'(k);
      tick();
    end
    bus.samp_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("s6_rst_window",    bus.window_out,      128'(0));
    check("s6_rst_req_ready", 128'(bus.req_ready), 128'(1));
    check("s6_rst_win_valid", 128'(bus.win_valid), 128'(0));
    check("s6_rst_errs",      128'({bus.err_overrun, bus.err_angle}), 128'(0));
    // Drain two samples still in flight from the serializer.
    bus.samp_valid = 1'b1;
    bus.samp_data  = 8'h57;
    tick();
    tick();
    bus.samp_valid = 1'b0;
    check("s6_drain_overrun", 128'(bus.err_overrun), 128'(1));
    check("s6_drain_window",  bus.window_out,        128'(0));
    request(6'd2);
    check("s6_ser_load", 128'(bus.ser_load), 128'(1));
    tick();
    feed(8'hA0);
    check("s6_window",     bus.window_out,      exp_win(8'hA0));
    check("s6_win_rotate", 128'(bus.win_rotate), 128'(2));
    check("s6_sum",        128'(bus.sum_out),    SUM_EN ? 128'(2680) : 128'(0));
    $display("window angle=%0d collected after reset", bus.win_rotate);
    release_win();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
